// File: rtl/wb_result_buffer.sv
// Result holding FIFO between an execution unit's result stage and writeback arbitration.
// Latency: a result pushed in cycle N is offered on wb_done/wb_id/wb_rd in cycle N+1 (no bypass).
// Backpressure: result_ready drops when all DEPTH entries are held; it depends only on registered count.
module wb_result_buffer #(
  parameter int DEPTH = 2,
  parameter int ID_W = 8,
  localparam int LOG2_DEPTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  result_valid,
  input  logic [ID_W-1:0]       result_id,
  input  logic [31:0]           result_data,
  output logic                  result_ready,
  output logic                  wb_done,
  output logic [ID_W-1:0]       wb_id,
  output logic [31:0]           wb_rd,
  input  logic                  wb_ack,
  output logic [LOG2_DEPTH:0]   occupancy
);

  localparam logic [LOG2_DEPTH:0] FULL_CNT = (LOG2_DEPTH+1)'(DEPTH);

  // Entry storage; contents are not reset, only the pointers and count are.
  logic [ID_W-1:0]       id_mem   [DEPTH];
  logic [31:0]           data_mem [DEPTH];
  logic [LOG2_DEPTH-1:0] rptr;
  logic [LOG2_DEPTH-1:0] wptr;
  logic [LOG2_DEPTH:0]   count;
  logic [LOG2_DEPTH:0]   count_next;
  logic                  push;
  logic                  pop;

  // Handshakes: full/empty status comes straight from count, so no wb_ack -> result_ready path.
  always_comb begin
    result_ready = (count != FULL_CNT);
    wb_done      = (count != '0);
    push         = result_valid & result_ready;
    pop          = wb_ack & wb_done;
    count_next   = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Pointer and count registers; reset empties the buffer immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count_next;
    end
  end

  // Write the incoming result into the slot at wptr.
  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wptr]   <= result_id;
      data_mem[wptr] <= result_data;
    end
  end

  // Head entry is presented directly from the array.
  always_comb begin
    wb_id     = id_mem[rptr];
    wb_rd     = data_mem[rptr];
    occupancy = count;
  end

`ifndef SYNTHESIS
  // Flag protocol misuse by the unit or the writeback arbiter.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(wb_ack && !wb_done))
        else $warning("wb_result_buffer: wb_ack with no entry held, ignored");
      assert (!(result_valid && !result_ready))
        else $warning("wb_result_buffer: result_valid while full, result dropped");
    end
  end
`endif

endmodule

// File: tb/tb_wb_result_buffer.sv
module tb_wb_result_buffer;

  localparam int DEPTH = 2;
  localparam int ID_W  = 8;
  localparam int OW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            result_valid = 1'b0;
  logic [ID_W-1:0] result_id = '0;
  logic [31:0]     result_data = '0;
  logic            result_ready;
  logic            wb_done;
  logic [ID_W-1:0] wb_id;
  logic [31:0]     wb_rd;
  logic            wb_ack = 1'b0;
  logic [OW-1:0]   occupancy;

  int errors = 0;
  int checks = 0;

  // Scoreboard of {id, data}, oldest at index 0.
  logic [ID_W+31:0] sb[$];

  wb_result_buffer #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .result_valid(result_valid), .result_id(result_id), .result_data(result_data),
    .result_ready(result_ready),
    .wb_done(wb_done), .wb_id(wb_id), .wb_rd(wb_rd), .wb_ack(wb_ack),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Expected {wb_done, occupancy, result_ready} from the scoreboard.
  function automatic logic [OW+1:0] exp_status();
    return {(sb.size() != 0), OW'(sb.size()), (sb.size() != DEPTH)};
  endfunction

  // Drive one cycle of inputs (from a negedge), update the model at the posedge, return at the next negedge.
  task automatic drive_cycle(input logic v, input logic [ID_W-1:0] id, input logic [31:0] d, input logic ack);
    logic do_push, do_pop;
    result_valid = v;
    result_id    = id;
    result_data  = d;
    wb_ack       = ack;
    do_push = v && (sb.size() < DEPTH);
    do_pop  = ack && (sb.size() > 0);
    @(posedge clk);
    if (do_pop) void'(sb.pop_front());
    if (do_push) sb.push_back({id, d});
    @(negedge clk);
    result_valid = 1'b0;
    wb_ack       = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    if ({wb_done, occupancy, result_ready} !== exp_status()) begin
      errors++;
      $display("FAIL reset_status: got done/occ/ready=%b required %b", {wb_done, occupancy, result_ready}, exp_status());
    end
    checks++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_push();
    drive_cycle(1'b1, 8'd3, 32'hDEADBEEF, 1'b0);
    if ({wb_done, occupancy, result_ready} !== 4'b1011 || {wb_id, wb_rd} !== {8'd3, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL single_push: got st=%b id=%0d rd=%h required st=1011 id=3 rd=deadbeef",
               {wb_done, occupancy, result_ready}, wb_id, wb_rd);
    end
    checks++;
    drive_cycle(1'b0, '0, '0, 1'b1);
    if ({wb_done, occupancy, result_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL single_pop: got st=%b required 0001", {wb_done, occupancy, result_ready});
    end
    checks++;
  endtask

  task automatic test_fill_full();
    for (int i = 1; i <= 3; i++) begin
      drive_cycle(1'b1, ID_W'(i), 32'hA000_0000 + i, 1'b0);
      if ({wb_done, occupancy, result_ready} !== exp_status()) begin
        errors++;
        $display("FAIL fill_status_%0d: got %b required %b", i, {wb_done, occupancy, result_ready}, exp_status());
      end
      checks++;
    end
    for (int i = 0; i < 3; i++) begin
      if (sb.size() != 0) begin
        if ({wb_id, wb_rd} !== sb[0]) begin
          errors++;
          $display("FAIL fill_drain_head_%0d: got id=%0d rd=%h required id=%0d rd=%h",
                   i, wb_id, wb_rd, sb[0][ID_W+31:32], sb[0][31:0]);
        end
        checks++;
      end
      drive_cycle(1'b0, '0, '0, 1'b1);
      if ({wb_done, occupancy, result_ready} !== exp_status()) begin
        errors++;
        $display("FAIL fill_drain_status_%0d: got %b required %b", i, {wb_done, occupancy, result_ready}, exp_status());
      end
      checks++;
    end
  endtask

  task automatic test_full_with_ack();
    drive_cycle(1'b1, 8'd21, 32'h21, 1'b0);
    drive_cycle(1'b1, 8'd22, 32'h22, 1'b0);
    if (result_ready !== 1'b0 || occupancy !== OW'(2)) begin
      errors++;
      $display("FAIL full_before_ack: got ready=%b occ=%0d required ready=0 occ=2", result_ready, occupancy);
    end
    checks++;
    drive_cycle(1'b1, 8'd23, 32'h23, 1'b1);
    if ({wb_done, occupancy, result_ready} !== 4'b1011 || {wb_id, wb_rd} !== sb[0]) begin
      errors++;
      $display("FAIL full_ack_no_push: got st=%b id=%0d required st=1011 id=22", {wb_done, occupancy, result_ready}, wb_id);
    end
    checks++;
    drive_cycle(1'b1, 8'd24, 32'h24, 1'b0);
    if (occupancy !== OW'(2)) begin
      errors++;
      $display("FAIL full_repush: got occ=%0d required 2", occupancy);
    end
    checks++;
    for (int i = 0; i < 2; i++) begin
      if ({wb_id, wb_rd} !== sb[0]) begin
        errors++;
        $display("FAIL full_drain_%0d: got id=%0d required id=%0d", i, wb_id, sb[0][ID_W+31:32]);
      end
      checks++;
      drive_cycle(1'b0, '0, '0, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    int popped = 0;
    int max_occ = 0;
    for (int i = 0; i < 11; i++) begin
      logic ack;
      ack = (sb.size() != 0);
      if (ack) begin
        if (wb_done !== 1'b1 || {wb_id, wb_rd} !== sb[0]) begin
          errors++;
          $display("FAIL stream_head_%0d: got done=%b id=%0d rd=%h required id=%0d rd=%h",
                   i, wb_done, wb_id, wb_rd, sb[0][ID_W+31:32], sb[0][31:0]);
        end
        checks++;
        popped++;
      end
      if (i < 10) drive_cycle(1'b1, ID_W'(i), 32'(i * 32'h11), ack);
      else        drive_cycle(1'b0, '0, '0, ack);
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
    end
    if (popped != 10 || max_occ > 1 || wb_done !== 1'b0) begin
      errors++;
      $display("FAIL stream_summary: got popped=%0d max_occ=%0d done=%b required 10/1/0", popped, max_occ, wb_done);
    end
    checks++;
  endtask

  task automatic test_spurious_ack();
    drive_cycle(1'b0, '0, '0, 1'b1);
    if ({wb_done, occupancy, result_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL spurious_ack: got st=%b required 0001", {wb_done, occupancy, result_ready});
    end
    checks++;
    drive_cycle(1'b1, 8'd5, 32'h5555_0005, 1'b0);
    if ({wb_done, occupancy} !== 3'b101 || {wb_id, wb_rd} !== {8'd5, 32'h5555_0005}) begin
      errors++;
      $display("FAIL spurious_then_push: got done=%b occ=%0d id=%0d rd=%h required 1/1/5/55550005",
               wb_done, occupancy, wb_id, wb_rd);
    end
    checks++;
    drive_cycle(1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_async_reset();
    drive_cycle(1'b1, 8'd31, 32'h31, 1'b0);
    drive_cycle(1'b1, 8'd32, 32'h32, 1'b0);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    if ({wb_done, occupancy, result_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL async_reset: got st=%b required 0001 before next edge", {wb_done, occupancy, result_ready});
    end
    checks++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_cycle(1'b1, 8'd7, 32'h0777_7777, 1'b0);
    if ({wb_done, occupancy} !== 3'b101 || {wb_id, wb_rd} !== {8'd7, 32'h0777_7777}) begin
      errors++;
      $display("FAIL after_reset_push: got done=%b occ=%0d id=%0d required 1/1/7", wb_done, occupancy, wb_id);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_full();
    test_full_with_ack();
    test_back_to_back();
    test_spurious_ack();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
